dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data memory (ce0/we0/address0/d0/q0, one-cycle read latency) between the riscv_kernel load/store port (port 0) and a loader/debug DMA port (port 1). It sits between the kernel and riscv_kernel_dmem and drives the memory's port directly. Port 0 has fixed priority; a starvation counter and a lock mode guarantee port 1 forward progress. The arbiter also routes returning read data back to the requester that issued the read.

## Interface
- AW, 5, dmem word-address width
- DW, 32, data width
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before a forced grant (1..15)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- p0_req / p1_req  in  1  access request, held until granted
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  AW  word address
- p0_wdata / p1_wdata  in  DW  write data
- p1_lock  in  1  port 1 requests back-to-back ownership
- p0_gnt / p1_gnt  out  1  access accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  read data valid, one cycle after the granted read
- p0_rdata / p1_rdata  out  DW  read data; 0 when the matching rvalid is 0
- mem_address0  out  AW  to dmem address0
- mem_ce0  out  1  to dmem ce0
- mem_we0  out  1  to dmem we0
- mem_d0  out  DW  to dmem d0
- mem_q0  in  DW  from dmem q0, valid one cycle after a ce0 read
- starve_cnt  out  4  current port-1 denial count, for debug

## Operation
- FSM states: ARB (normal priority arbitration) and LOCK1 (port 1 owns memory).
- ARB: p0_req and not forced -> grant port 0. Else p1_req -> grant port 1. Forced = p1_req and starve_cnt == MAX_WAIT; forced grants port 1 even if p0_req is asserted.
- ARB -> LOCK1 when port 1 is granted with p1_lock = 1.
- LOCK1: port 1 is granted whenever p1_req = 1. Port 0 is never granted. Stay while p1_lock = 1. Return to ARB on the first cycle p1_lock = 0; that cycle is itself arbitrated as ARB.
- LOCK1 time limit: after 16 consecutive LOCK1 cycles, force ARB for at least one cycle, giving port 0 a grant opportunity.
- starve_cnt: increments (saturating at MAX_WAIT) each cycle p1_req = 1 and p1_gnt = 0. Clears on p1_gnt or p1_req = 0.
- Memory drive: mem_ce0 = p0_gnt | p1_gnt. mem_we0, mem_address0 and mem_d0 come from the granted port. With no grant, mem_we0, mem_address0 and mem_d0 are 0.
- Response tracking: register rd_pend (1 bit) and rd_owner (1 bit) on every granted read. In the next cycle the owner's rvalid = 1 and its rdata = mem_q0. Writes produce no rvalid.
- Only one access per cycle. Both gnts are never high together.

## Timing
- Reset (rst = 0 at a rising edge): state = ARB, starve_cnt = 0, rd_pend = 0. While rst = 0, all gnts, rvalids, mem_ce0 and mem_we0 are forced to 0. All rdata and mem_address0/mem_d0 are 0.
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req, when the request wins.
- Read latency: a read granted in cycle N has rvalid in cycle N+1. Throughput is one access per cycle, including back-to-back reads alternating between owners.
- Reset mid-read: a read granted in the cycle before reset produces no rvalid after reset.
- Simultaneous p0/p1 requests in ARB with starve_cnt < MAX_WAIT: port 0 wins. With starve_cnt == MAX_WAIT: port 1 wins and the count clears next cycle.
- A read and a write to the same address in consecutive cycles: the read returns the pre-write value if the read is first. Ordering is strictly by grant order.

## Test plan
- Reset: hold rst = 0 with both reqs high -> no gnt, mem_ce0 = 0. Release rst -> p0_gnt in the first cycle and starve_cnt = 0.
- Port 0 read: address 3, with ram[3] = 6 -> p0_gnt in the same cycle, p0_rvalid next cycle with p0_rdata = 6, and p1_rvalid = 0.
- Starvation: p0_req held high with p1_req high, MAX_WAIT = 4 -> p1_gnt in the 5th cycle, then starve_cnt = 0, then port 0 resumes.
- Lock: p1_lock = 1 while port 1 writes 1, 5, 8, 7 to addresses 0..3 while p0_req is high -> four consecutive p1_gnts, no p0_gnt. Drop the lock -> p0_gnt. ram[0..3] = 1, 5, 8, 7.
- LOCK1 time limit: p1_lock held for 20 cycles with p0_req high -> p0_gnt occurs in the cycle after the 16th LOCK1 cycle.
- Interleaved reads: p0 reads address 9 (value 44), then p1 reads address 1 (value 13) in the next cycle -> p0_rvalid/44, then p1_rvalid/13, in consecutive cycles.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares the single-port synchronous-read data memory between the kernel
// load/store port (port 0, fixed priority) and a loader/debug DMA port
// (port 1). Port 1 forward progress is guaranteed in two ways:
//   - Starvation: after MAX_WAIT consecutive denials, port 1 is granted
//     even when port 0 is requesting.
//   - Lock: port 1 may hold the memory back to back by asserting p1_lock.
//     Lock ownership is capped at 16 cycles, so port 0 always gets a chance.
// Returning read data is steered to the port that issued the read.
//
// Ports
//   clk, rst                    clock, synchronous active-low reset
//   p0_* / p1_*                 requester ports (req/we/addr/wdata in,
//                               gnt/rvalid/rdata out); p1_lock selects lock
//   mem_address0/ce0/we0/d0     memory command, driven from the granted port
//   mem_q0                      memory read data, one cycle after a read
//   starve_cnt                  current port-1 denial count (debug)
module dmem_port_arbiter #(
   parameter int unsigned AW       = 5,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [DW-1:0] p0_rdata,

   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   input  logic          p1_lock,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [DW-1:0] p1_rdata,

   output logic [AW-1:0] mem_address0,
   output logic          mem_ce0,
   output logic          mem_we0,
   output logic [DW-1:0] mem_d0,
   input  logic [DW-1:0] mem_q0,

   output logic [3:0]    starve_cnt
);

   typedef enum logic [0:0] {StArb, StLock1} state_e;

   localparam logic [3:0] MaxWait  = 4'(MAX_WAIT);
   // Index of the 16th consecutive LOCK1 cycle.
   localparam logic [3:0] LockLast = 4'd15;

   state_e     state_q;
   logic [3:0] starve_q;
   logic [3:0] lock_cnt_q;
   logic       rd_pend_q;
   logic       rd_owner_q;   // 0 = port 0, 1 = port 1

   logic       arb_mode;
   logic       forced;
   logic       gnt0;
   logic       gnt1;

   // ---------------------------------------------------------------------
   // Grant decision
   // ---------------------------------------------------------------------
   always_comb begin
      // Dropping the lock while in LOCK1 makes that very cycle a normal
      // arbitration cycle.
      arb_mode = (state_q == StArb) || !p1_lock;
      forced   = p1_req && (starve_q == MaxWait);
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (rst) begin
         if (arb_mode) begin
            if (p0_req && !forced) begin
               gnt0 = 1'b1;
            end else if (p1_req) begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt1 = p1_req;
         end
      end
   end

   assign p0_gnt     = gnt0;
   assign p1_gnt     = gnt1;
   assign starve_cnt = starve_q;

   // ---------------------------------------------------------------------
   // Memory command from the granted port; idle bus is all zeros
   // ---------------------------------------------------------------------
   always_comb begin
      mem_ce0      = gnt0 | gnt1;
      mem_we0      = 1'b0;
      mem_address0 = '0;
      mem_d0       = '0;
      if (gnt0) begin
         mem_we0      = p0_we;
         mem_address0 = p0_addr;
         mem_d0       = p0_wdata;
      end else if (gnt1) begin
         mem_we0      = p1_we;
         mem_address0 = p1_addr;
         mem_d0       = p1_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Read response routing (gated by rst so nothing leaks during reset)
   // ---------------------------------------------------------------------
   always_comb begin
      p0_rvalid = rst && rd_pend_q && !rd_owner_q;
      p1_rvalid = rst && rd_pend_q &&  rd_owner_q;
      p0_rdata  = p0_rvalid ? mem_q0 : '0;
      p1_rdata  = p1_rvalid ? mem_q0 : '0;
   end

   // ---------------------------------------------------------------------
   // State: FSM, starvation counter, lock timer, pending read
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StArb;
         starve_q   <= 4'd0;
         lock_cnt_q <= 4'd0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         // Starvation counter: count denials, saturate, clear otherwise.
         if (p1_req && !gnt1) begin
            if (starve_q != MaxWait) begin
               starve_q <= starve_q + 4'd1;
            end
         end else begin
            starve_q <= 4'd0;
         end

         if (arb_mode) begin
            lock_cnt_q <= 4'd0;
            state_q    <= (gnt1 && p1_lock) ? StLock1 : StArb;
         end else if (lock_cnt_q == LockLast) begin
            // Lock time limit reached: hand one arbitration cycle back.
            lock_cnt_q <= 4'd0;
            state_q    <= StArb;
         end else begin
            lock_cnt_q <= lock_cnt_q + 4'd1;
         end

         rd_pend_q  <= (gnt0 || gnt1) && !mem_we0;
         rd_owner_q <= gnt1;
      end
   end

   // Single-port memory: at most one access per cycle.
   a_one_grant : assert property (@(posedge clk) !(gnt0 && gnt1));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   localparam int unsigned AW       = 5;
   localparam int unsigned DW       = 32;
   localparam int unsigned MAX_WAIT = 4;
   localparam int          Depth    = 1 << AW;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          p0_req, p0_we, p0_gnt, p0_rvalid;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata, p0_rdata;
   logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata, p1_rdata;
   logic [AW-1:0] mem_address0;
   logic          mem_ce0, mem_we0;
   logic [DW-1:0] mem_d0, mem_q0;
   logic [3:0]    starve_cnt;

   dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
      .mem_d0(mem_d0), .mem_q0(mem_q0), .starve_cnt(starve_cnt)
   );

   // Synchronous-read single-port RAM standing in for riscv_kernel_dmem.
   logic [DW-1:0] ram [Depth];
   always @(posedge clk) begin
      if (mem_ce0) begin
         if (mem_we0) ram[mem_address0] <= mem_d0;
         else         mem_q0 <= ram[mem_address0];
      end
   end

   typedef struct {
      logic          rst;
      logic          p0_req;
      logic          p0_we;
      logic [AW-1:0] p0_addr;
      logic [DW-1:0] p0_wdata;
      logic          p1_req;
      logic          p1_we;
      logic [AW-1:0] p1_addr;
      logic [DW-1:0] p1_wdata;
      logic          p1_lock;
      logic          e_g0;
      logic          e_g1;
      logic          e_v0;
      logic          e_v1;
      logic [DW-1:0] e_rdata;
      logic [3:0]    e_starve;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Reference model: memory contents, lock ownership, denial count and
   // the one read response due next cycle.
   logic [DW-1:0] m_mem [Depth];
   bit            m_in_lock;
   int            m_lock_run;
   int            m_denied;
   bit            m_resp_v;
   bit            m_resp_owner;
   logic [DW-1:0] m_resp_data;

   // Values sampled from the DUT in the most recent step.
   logic          s_g0, s_g1, s_v0, s_v1;
   logic [DW-1:0] s_rdata;
   logic [3:0]    s_starve;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input vec_t v, input bit use_tab);
      bit            arb, forced, g0, g1, ev0, ev1, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      rst      = v.rst;
      p0_req   = v.p0_req;   p0_we = v.p0_we;   p0_addr = v.p0_addr;
      p0_wdata = v.p0_wdata;
      p1_req   = v.p1_req;   p1_we = v.p1_we;   p1_addr = v.p1_addr;
      p1_wdata = v.p1_wdata; p1_lock = v.p1_lock;
      @(negedge clk);
      s_g0 = p0_gnt; s_g1 = p1_gnt; s_v0 = p0_rvalid; s_v1 = p1_rvalid;
      s_rdata = p0_rdata | p1_rdata; s_starve = starve_cnt;

      // Who should own the memory this cycle.
      arb    = !m_in_lock || !v.p1_lock;
      forced = v.p1_req && (m_denied == int'(MAX_WAIT));
      g0 = 1'b0; g1 = 1'b0;
      if (v.rst) begin
         if (arb) begin
            g1 = v.p1_req && (forced || !v.p0_req);
            g0 = v.p0_req && !g1;
         end else begin
            g1 = v.p1_req;
         end
      end
      we = g0 ? v.p0_we    : (g1 ? v.p1_we    : 1'b0);
      a  = g0 ? v.p0_addr  : (g1 ? v.p1_addr  : '0);
      d  = g0 ? v.p0_wdata : (g1 ? v.p1_wdata : '0);
      ev0 = v.rst && m_resp_v && !m_resp_owner;
      ev1 = v.rst && m_resp_v &&  m_resp_owner;

      chk("p0_gnt", p0_gnt, g0);
      chk("p1_gnt", p1_gnt, g1);
      chk("mem_ce0", mem_ce0, g0 | g1);
      chk("mem_we0", mem_we0, we);
      chk("mem_address0", mem_address0, a);
      chk("mem_d0", mem_d0, d);
      chk("p0_rvalid", p0_rvalid, ev0);
      chk("p1_rvalid", p1_rvalid, ev1);
      chk("p0_rdata", p0_rdata, ev0 ? m_resp_data : '0);
      chk("p1_rdata", p1_rdata, ev1 ? m_resp_data : '0);
      chk("starve_cnt", starve_cnt, 4'(m_denied));

      if (use_tab) begin
         chk("tab_g0", s_g0, v.e_g0);
         chk("tab_g1", s_g1, v.e_g1);
         chk("tab_v0", s_v0, v.e_v0);
         chk("tab_v1", s_v1, v.e_v1);
         chk("tab_rdata", s_rdata, v.e_rdata);
         chk("tab_starve", s_starve, v.e_starve);
      end

      // Advance the model to the next cycle.
      if (!v.rst) begin
         m_in_lock = 1'b0; m_lock_run = 0; m_denied = 0; m_resp_v = 1'b0;
      end else begin
         if (v.p1_req && !g1) m_denied = (m_denied < int'(MAX_WAIT)) ? m_denied + 1 : m_denied;
         else                 m_denied = 0;
         if (arb) begin
            m_in_lock  = g1 && v.p1_lock;
            m_lock_run = 0;
         end else begin
            m_lock_run++;
            if (m_lock_run >= 16) begin
               m_in_lock  = 1'b0;
               m_lock_run = 0;
            end
         end
         m_resp_v = 1'b0;
         if (g0 || g1) begin
            if (we) m_mem[a] = d;
            else begin
               m_resp_v     = 1'b1;
               m_resp_owner = g1;
               m_resp_data  = m_mem[a];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tab [20];
   vec_t v;

   initial begin
      // rst p0r p0w p0a p0d  p1r p1w p1a p1d lk   g0 g1 v0 v1 rdata starve
      tab[0]  = '{0, 1, 0, 3, 0,  1, 0, 9, 0, 0,   0, 0, 0, 0, 0,  0};
      tab[1]  = '{0, 1, 0, 3, 0,  1, 0, 9, 0, 0,   0, 0, 0, 0, 0,  0};
      tab[2]  = '{1, 1, 0, 3, 0,  1, 0, 9, 0, 0,   1, 0, 0, 0, 0,  0};
      tab[3]  = '{1, 1, 0, 3, 0,  1, 0, 9, 0, 0,   1, 0, 1, 0, 6,  1};
      tab[4]  = '{1, 1, 0, 3, 0,  1, 0, 9, 0, 0,   1, 0, 1, 0, 6,  2};
      tab[5]  = '{1, 1, 0, 3, 0,  1, 0, 9, 0, 0,   1, 0, 1, 0, 6,  3};
      tab[6]  = '{1, 1, 0, 3, 0,  1, 0, 9, 0, 0,   0, 1, 1, 0, 6,  4};
      tab[7]  = '{1, 1, 0, 3, 0,  1, 0, 9, 0, 0,   1, 0, 0, 1, 44, 0};
      tab[8]  = '{1, 1, 0, 9, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 6,  1};
      tab[9]  = '{1, 0, 0, 0, 0,  1, 0, 1, 0, 0,   0, 1, 1, 0, 44, 0};
      tab[10] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 1, 13, 0};
      tab[11] = '{1, 0, 0, 0, 0,  1, 1, 0, 1, 1,   0, 1, 0, 0, 0,  0};
      tab[12] = '{1, 1, 0, 3, 0,  1, 1, 1, 5, 1,   0, 1, 0, 0, 0,  0};
      tab[13] = '{1, 1, 0, 3, 0,  1, 1, 2, 8, 1,   0, 1, 0, 0, 0,  0};
      tab[14] = '{1, 1, 0, 3, 0,  1, 1, 3, 7, 1,   0, 1, 0, 0, 0,  0};
      tab[15] = '{1, 1, 0, 3, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0};
      tab[16] = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 7,  0};
      tab[17] = '{1, 1, 0, 1, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 1,  0};
      tab[18] = '{1, 1, 0, 2, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 5,  0};
      tab[19] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 1, 0, 8,  0};

      for (int i = 0; i < Depth; i++) begin
         ram[i]   = 32'h100 + 32'(i);
         m_mem[i] = 32'h100 + 32'(i);
      end
      ram[3] = 6;  m_mem[3] = 6;
      ram[9] = 44; m_mem[9] = 44;
      ram[1] = 13; m_mem[1] = 13;
      m_in_lock = 1'b0; m_lock_run = 0; m_denied = 0; m_resp_v = 1'b0;
      m_resp_owner = 1'b0; m_resp_data = '0;

      // Initial reset before any checking.
      rst = 1'b0; p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_lock = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset, port-0 read, starvation, interleaved reads, lock writes.
      for (int i = 0; i < 20; i++) step(tab[i], 1'b1);

      // Lock time limit: port 1 forced in, then holds LOCK1 for 16 cycles.
      v = '{1, 1, 0, 3, 0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 22; i++) begin
         step(v, 1'b0);
         chk("lock_limit_g1", s_g1, (i >= 4 && i <= 20) ? 1'b1 : 1'b0);
         chk("lock_limit_g0", s_g0, (i < 4 || i == 21) ? 1'b1 : 1'b0);
      end
      v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      step(v, 1'b0);

      // Reset in the cycle after a granted read: no response must appear.
      v = '{1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      step(v, 1'b0);
      chk("rmr_gnt", s_g0, 1'b1);
      v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      step(v, 1'b0);
      chk("rmr_v0_in_reset", s_v0, 1'b0);
      v.rst = 1'b1;
      step(v, 1'b0);
      chk("rmr_v0_after", s_v0, 1'b0);
      chk("rmr_v1_after", s_v1, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         v.rst      = ($urandom_range(0, 63) != 0);
         v.p0_req   = ($urandom_range(0, 3) != 0);
         v.p0_we    = $urandom_range(0, 1);
         v.p0_addr  = AW'($urandom);
         v.p0_wdata = $urandom;
         v.p1_req   = ($urandom_range(0, 2) != 0);
         v.p1_we    = $urandom_range(0, 1);
         v.p1_addr  = AW'($urandom);
         v.p1_wdata = $urandom;
         v.p1_lock  = ($urandom_range(0, 3) != 0);
         step(v, 1'b0);
      end

      for (int i = 0; i < Depth; i++) chk("final_ram", ram[i], m_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
